// File: rtl/block_gen.sv
// Piece generator: an LFSR draws piece codes into an active slot and a one-deep preview,
// rejecting out-of-range codes and suppressing one immediate repeat of the active piece.
module block_gen #(
   parameter int unsigned NUM_BLOCKS = 5,
   parameter logic [15:0] SEED       = 16'hACE1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       req,
   output logic [2:0] block_num,
   output logic [2:0] next_num,
   output logic       valid,
   output logic       spawn
);

   typedef enum logic [1:0] {
      FILL0  = 2'd0,
      FILL1  = 2'd1,
      READY  = 2'd2,
      REFILL = 2'd3
   } state_t;

   // An all-zero seed would lock the LFSR, so it is promoted to 1.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [3:0]  LIMIT    = 4'(NUM_BLOCKS);

   state_t      state_r;
   logic [15:0] lfsr_r;
   logic        reroll_r;
   logic [2:0]  cand_s;
   logic        legal_s;

   function automatic logic lfsr_fb(input logic [15:0] v);
      return v[15] ^ v[13] ^ v[12] ^ v[10];
   endfunction

   // Candidate code and its legality, taken from the pre-update LFSR value.
   always_comb begin
      cand_s  = lfsr_r[2:0];
      legal_s = ({1'b0, cand_s} < LIMIT);
   end

   // Free-running LFSR, frozen while disabled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_r <= SEED_EFF;
      end else if (enable) begin
         lfsr_r <= {lfsr_r[14:0], lfsr_fb(lfsr_r)};
      end else begin
         lfsr_r <= lfsr_r;
      end
   end

   // Fill / serve / refill state machine with registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= FILL0;
         block_num <= 3'd0;
         next_num  <= 3'd0;
         valid     <= 1'b0;
         spawn     <= 1'b0;
         reroll_r  <= 1'b0;
      end else begin
         spawn <= 1'b0;
         if (enable) begin
            case (state_r)
               FILL0: begin
                  if (legal_s) begin
                     block_num <= cand_s;
                     state_r   <= FILL1;
                  end
               end
               FILL1: begin
                  if (legal_s) begin
                     next_num <= cand_s;
                     valid    <= 1'b1;
                     state_r  <= READY;
                  end
               end
               READY: begin
                  if (req) begin
                     block_num <= next_num;
                     valid     <= 1'b0;
                     spawn     <= 1'b1;
                     reroll_r  <= 1'b0;
                     state_r   <= REFILL;
                  end
               end
               REFILL: begin
                  // A repeat of the active piece is thrown away once, then allowed.
                  if (legal_s) begin
                     if ((cand_s == block_num) && !reroll_r) begin
                        reroll_r <= 1'b1;
                     end else begin
                        next_num <= cand_s;
                        valid    <= 1'b1;
                        state_r  <= READY;
                     end
                  end
               end
               default: begin
                  state_r <= FILL0;
                  valid   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_block_gen.sv
// Directed bench for block_gen: three instances with different seeds cover fill,
// rejection, freeze, reroll and asynchronous reset mid-refill.
module tb_block_gen;

   logic clk;
   logic rst_a, en_a, req_a;
   logic rst_bc, en_bc, req_b, req_c;
   logic [2:0] blk_a, nxt_a, blk_b, nxt_b, blk_c, nxt_c;
   logic val_a, spn_a, val_b, spn_b, val_c, spn_c;
   int tests;
   int fails;

   block_gen #(.NUM_BLOCKS(5), .SEED(16'h0001)) dut_a (
      .clk(clk), .rst_n(rst_a), .enable(en_a), .req(req_a),
      .block_num(blk_a), .next_num(nxt_a), .valid(val_a), .spawn(spn_a));

   block_gen #(.NUM_BLOCKS(5), .SEED(16'h0007)) dut_b (
      .clk(clk), .rst_n(rst_bc), .enable(en_bc), .req(req_b),
      .block_num(blk_b), .next_num(nxt_b), .valid(val_b), .spawn(spn_b));

   block_gen #(.NUM_BLOCKS(4), .SEED(16'h81F1)) dut_c (
      .clk(clk), .rst_n(rst_bc), .enable(en_bc), .req(req_c),
      .block_num(blk_c), .next_num(nxt_c), .valid(val_c), .spawn(spn_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [2:0] b, input logic [2:0] n,
                        input logic v, input logic s);
      chk({tag, ".block"}, 16'(blk_a), 16'(b));
      chk({tag, ".next"},  16'(nxt_a), 16'(n));
      chk({tag, ".valid"}, 16'(val_a), 16'(v));
      chk({tag, ".spawn"}, 16'(spn_a), 16'(s));
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      rst_a  = 1'b0;
      rst_bc = 1'b0;
      en_a   = 1'b1;
      en_bc  = 1'b1;
      req_a  = 1'b0;
      req_b  = 1'b0;
      req_c  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_a("a_reset", 3'd0, 3'd0, 1'b0, 1'b0);
      chk("a_reset.lfsr", dut_a.lfsr_r, 16'h0001);
      chk("b_reset.block", 16'(blk_b), 16'd0);
      rst_a  = 1'b1;
      rst_bc = 1'b1;

      // edge 1
      @(negedge clk);
      chk_a("a_e1", 3'd1, 3'd0, 1'b0, 1'b0);
      chk("b_e1.block", 16'(blk_b), 16'd0);
      chk("b_e1.valid", 16'(val_b), 16'd0);
      chk("c_e1.block", 16'(blk_c), 16'd1);

      // edge 2
      @(negedge clk);
      chk_a("a_e2", 3'd1, 3'd2, 1'b1, 1'b0);
      chk("b_e2.block", 16'(blk_b), 16'd0);
      chk("c_e2.next", 16'(nxt_c), 16'd3);
      chk("c_e2.valid", 16'(val_c), 16'd1);

      // edge 3: instance a frozen from here for 10 edges
      en_a = 1'b0;
      @(negedge clk);
      chk_a("a_frz3", 3'd1, 3'd2, 1'b1, 1'b0);
      chk("b_e3.block", 16'(blk_b), 16'd4);
      chk("b_e3.valid", 16'(val_b), 16'd0);

      // edge 4: req pulsed on a (frozen) and c (ready)
      req_a = 1'b1;
      req_c = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      req_c = 1'b0;
      chk_a("a_frz4", 3'd1, 3'd2, 1'b1, 1'b0);
      chk("b_e4.next", 16'(nxt_b), 16'd0);
      chk("b_e4.valid", 16'(val_b), 16'd1);
      chk("c_e4.block", 16'(blk_c), 16'd3);
      chk("c_e4.valid", 16'(val_c), 16'd0);
      chk("c_e4.spawn", 16'(spn_c), 16'd1);

      // edge 5: first 3 in refill is rerolled
      @(negedge clk);
      chk_a("a_frz5", 3'd1, 3'd2, 1'b1, 1'b0);
      chk("c_e5.reroll", 16'(dut_c.reroll_r), 16'd1);
      chk("c_e5.valid", 16'(val_c), 16'd0);
      chk("c_e5.spawn", 16'(spn_c), 16'd0);

      // edges 6,7: candidates 6 and 5 rejected
      @(negedge clk);
      chk("c_e6.valid", 16'(val_c), 16'd0);
      @(negedge clk);
      chk("c_e7.valid", 16'(val_c), 16'd0);

      // edge 8: second 3 accepted
      @(negedge clk);
      chk("c_e8.next", 16'(nxt_c), 16'd3);
      chk("c_e8.valid", 16'(val_c), 16'd1);
      chk("c_e8.block", 16'(blk_c), 16'd3);

      // edges 9..12: a still frozen
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk_a("a_frz", 3'd1, 3'd2, 1'b1, 1'b0);
      end
      chk("a_frz.lfsr", dut_a.lfsr_r, 16'h0004);

      // a: accept req
      en_a  = 1'b1;
      req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      chk_a("a_e3", 3'd2, 3'd2, 1'b0, 1'b1);

      // asynchronous reset while a sits in REFILL
      rst_a = 1'b0;
      #1;
      chk_a("a_async_rst", 3'd0, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk("a_async_rst.lfsr", dut_a.lfsr_r, 16'h0001);
      rst_a = 1'b1;

      // replay after reset
      @(negedge clk);
      chk_a("a_r1", 3'd1, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      chk_a("a_r2", 3'd1, 3'd2, 1'b1, 1'b0);
      req_a = 1'b1;
      @(negedge clk);
      req_a = 1'b0;
      chk_a("a_r3", 3'd2, 3'd2, 1'b0, 1'b1);
      @(negedge clk);
      chk_a("a_r4", 3'd2, 3'd0, 1'b1, 1'b0);

      // req held over two edges: second edge lands in REFILL and is ignored
      req_a = 1'b1;
      @(negedge clk);
      chk_a("a_r5", 3'd0, 3'd0, 1'b0, 1'b1);
      @(negedge clk);
      req_a = 1'b0;
      chk_a("a_r6", 3'd0, 3'd0, 1'b0, 1'b0);
      chk("a_r6.reroll", 16'(dut_a.reroll_r), 16'd1);
      @(negedge clk);
      chk_a("a_r7", 3'd0, 3'd0, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
